// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-head PC sequencer: next-PC source encoding
// and default vectors.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_HOLD = 3'd1,
    SEL_JR   = 3'd2,
    SEL_RET  = 3'd3,
    SEL_BR   = 3'd4,
    SEL_J    = 3'd5,
    SEL_SEQ  = 3'd6
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with top pointer, saturating count and sticky
// overflow/underflow flags. A push into a full stack overwrites the oldest entry.
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_up;
  logic [PW-1:0]    ptr_dn;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign ptr_up  = ptr + PW'(1);
  assign ptr_dn  = ptr - PW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & ~empty;
  assign top     = mem[ptr];

  // ptr always addresses the most recent entry; a push writes one slot above it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clear) begin
        ptr   <= '0;
        count <= '0;
      end else if (do_push) begin
        ptr <= ptr_up;
        if (!full) count <= count + CW'(1);
      end else if (do_pop) begin
        ptr   <= ptr_dn;
        count <= count - CW'(1);
      end
      if (do_push && full)          overflow  <= 1'b1;
      if (pop && !clear && empty)   underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[ptr_up] <= pushData;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-fetch-address selection with a return-address stack
// for call/return. Drives the instruction memory address and IF/ID register.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             exception,
  input  logic             jumpReg,
  input  logic [WIDTH-1:0] jumpRegAddress,
  input  logic             ret,
  input  logic             branch,
  input  logic [WIDTH-1:0] branchAddress,
  input  logic             jump,
  input  logic [WIDTH-1:0] jumpAddress,
  input  logic             call,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] nextPC,
  output logic             rasEmpty,
  output logic             rasOverflow,
  output logic             rasUnderflow
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;

  assign pc_inc = PC + WIDTH'(INC);

  always_comb begin
    sel = SEL_SEQ;
    if (exception)    sel = SEL_EXC;
    else if (stall)   sel = SEL_HOLD;
    else if (jumpReg) sel = SEL_JR;
    else if (ret)     sel = SEL_RET;
    else if (branch)  sel = SEL_BR;
    else if (jump)    sel = SEL_J;
  end

  // A return with nothing on the stack falls through to the sequential address
  always_comb begin
    nextPC = pc_inc;
    case (sel)
      SEL_EXC:  nextPC = EXC_VECTOR;
      SEL_HOLD: nextPC = PC;
      SEL_JR:   nextPC = jumpRegAddress;
      SEL_RET:  nextPC = rasEmpty ? pc_inc : ras_top;
      SEL_BR:   nextPC = branchAddress;
      SEL_J:    nextPC = jumpAddress;
      default:  nextPC = pc_inc;
    endcase
  end

  assign ras_push = call & ((sel == SEL_JR) | (sel == SEL_J));
  assign ras_pop  = (sel == SEL_RET);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) PC <= RESET_VECTOR;
    else          PC <= nextPC;
  end

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (exception),
    .pushData  (pc_inc),
    .top       (ras_top),
    .empty     (rasEmpty),
    .overflow  (rasOverflow),
    .underflow (rasUnderflow)
  );

endmodule
